// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern buffer and its consumers.
package pattern_pkg;

    localparam int PAT_ADDR_W   = 5;
    localparam int PAT_BUF_SIZE = 32;
    localparam int PAT_BYTE_W   = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        HOLD = ST_HOLD
    } pat_state_t;

endpackage

// File: rtl/pattern_addr_gen.sv
// Next address inside a [first, last] window; wraps modulo the buffer depth,
// ascending or descending.
module pattern_addr_gen
    import pattern_pkg::*;
#(
    parameter int addr_w = PAT_ADDR_W
) (
    input  logic [addr_w-1:0] addr_i,
    input  logic [addr_w-1:0] first_i,
    input  logic [addr_w-1:0] last_i,
    input  logic              reverse_i,
    output logic [addr_w-1:0] next_o
);

    localparam logic [addr_w-1:0] ONE = 1;

    always_comb begin
        if (addr_i == last_i) begin
            next_o = first_i;
        end else if (reverse_i) begin
            next_o = addr_i - ONE;
        end else begin
            next_o = addr_i + ONE;
        end
    end

endmodule

// File: rtl/pattern_player.sv
// Plays a programmed address window of the pattern buffer onto pat_out.
// Optional descending playback with `define PATTERN_PLAYER_REVERSE_EN.
module pattern_player
    import pattern_pkg::*;
#(
    parameter int buffer_width = PAT_BYTE_W,
    parameter int buffer_size  = PAT_BUF_SIZE,
    parameter int hold_width   = 8,
    parameter int loop_width   = 8
) (
    input  logic                           sclk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
`ifdef PATTERN_PLAYER_REVERSE_EN
    input  logic                           reverse,
`endif
    input  logic [$clog2(buffer_size)-1:0] first_addr,
    input  logic [$clog2(buffer_size)-1:0] last_addr,
    input  logic [hold_width-1:0]          hold,
    input  logic [loop_width-1:0]          loops,
    input  logic [buffer_width-1:0]        field_byte,
    output logic [$clog2(buffer_size)-1:0] fieldp,
    output logic [buffer_width-1:0]        pat_out,
    output logic                           pat_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           load_ok
);

    localparam int AW = $clog2(buffer_size);
    localparam logic [hold_width-1:0] HOLD_ONE = 1;
    localparam logic [loop_width-1:0] LOOP_ONE = 1;

    pat_state_t              state_q, state_d;
    logic [AW-1:0]           fieldp_q, fieldp_d;
    logic [AW-1:0]           shown_q, shown_d;
    logic [AW-1:0]           first_q, first_d;
    logic [AW-1:0]           last_q, last_d;
    logic [buffer_width-1:0] pat_q, pat_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [hold_width-1:0]   hold_q, hold_d;
    logic [hold_width-1:0]   hcnt_q, hcnt_d;
    logic [loop_width-1:0]   loops_q, loops_d;
    logic [loop_width-1:0]   pass_q, pass_d;
    logic                    rev_q;
    logic [AW-1:0]           next_addr;
    logic                    pass_end;

`ifdef PATTERN_PLAYER_REVERSE_EN
    logic rev_d;
`else
    assign rev_q = 1'b0;
`endif

    pattern_addr_gen #(.addr_w(AW)) u_addr_gen (
        .addr_i   (fieldp_q),
        .first_i  (first_q),
        .last_i   (last_q),
        .reverse_i(rev_q),
        .next_o   (next_addr)
    );

    assign pass_end = (shown_q == last_q);

    always_comb begin
        state_d  = state_q;
        fieldp_d = fieldp_q;
        shown_d  = shown_q;
        first_d  = first_q;
        last_d   = last_q;
        pat_d    = pat_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        hold_d   = hold_q;
        hcnt_d   = hcnt_q;
        loops_d  = loops_q;
        pass_d   = pass_q;
`ifdef PATTERN_PLAYER_REVERSE_EN
        rev_d    = rev_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    first_d  = first_addr;
                    last_d   = last_addr;
                    hold_d   = hold;
                    loops_d  = loops;
`ifdef PATTERN_PLAYER_REVERSE_EN
                    rev_d    = reverse;
`endif
                    fieldp_d = first_addr;
                    pass_d   = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else begin
                    pat_d    = field_byte;
                    shown_d  = fieldp_q;
                    valid_d  = 1'b1;
                    hcnt_d   = hold_q;
                    fieldp_d = next_addr;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end else if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - HOLD_ONE;
                end else if (pass_end && loops_q != '0 && pass_q == loops_q - LOOP_ONE) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // fieldp already points at the following byte, so no gap at pass wrap
                    if (pass_end && pass_q != '1) begin
                        pass_d = pass_q + LOOP_ONE;
                    end
                    pat_d    = field_byte;
                    shown_d  = fieldp_q;
                    hcnt_d   = hold_q;
                    fieldp_d = next_addr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q  <= IDLE;
            fieldp_q <= '0;
            shown_q  <= '0;
            first_q  <= '0;
            last_q   <= '0;
            pat_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            hold_q   <= '0;
            hcnt_q   <= '0;
            loops_q  <= '0;
            pass_q   <= '0;
`ifdef PATTERN_PLAYER_REVERSE_EN
            rev_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fieldp_q <= fieldp_d;
            shown_q  <= shown_d;
            first_q  <= first_d;
            last_q   <= last_d;
            pat_q    <= pat_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
            hcnt_q   <= hcnt_d;
            loops_q  <= loops_d;
            pass_q   <= pass_d;
`ifdef PATTERN_PLAYER_REVERSE_EN
            rev_q    <= rev_d;
`endif
        end
    end

    assign fieldp    = fieldp_q;
    assign pat_out   = pat_q;
    assign pat_valid = valid_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign load_ok   = (state_q == IDLE);

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player against a buffer holding mem[i] = 0x10 + i.
module tb_pattern_player;

    logic       sclk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [4:0] first_addr;
    logic [4:0] last_addr;
    logic [7:0] hold;
    logic [7:0] loops;
    logic [7:0] field_byte;
    logic [4:0] fieldp;
    logic [7:0] pat_out;
    logic       pat_valid;
    logic       busy;
    logic       done;
    logic       load_ok;
`ifdef PATTERN_PLAYER_REVERSE_EN
    logic       reverse;
`endif

    logic [7:0] mem [32];
    int n_cmp = 0;
    int n_bad = 0;

    pattern_player #(
        .buffer_width(8),
        .buffer_size (32),
        .hold_width  (8),
        .loop_width  (8)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
`ifdef PATTERN_PLAYER_REVERSE_EN
        .reverse   (reverse),
`endif
        .first_addr(first_addr),
        .last_addr (last_addr),
        .hold      (hold),
        .loops     (loops),
        .field_byte(field_byte),
        .fieldp    (fieldp),
        .pat_out   (pat_out),
        .pat_valid (pat_valid),
        .busy      (busy),
        .done      (done),
        .load_ok   (load_ok)
    );

    assign field_byte = mem[fieldp];

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench one cycle after the edge that sampled start (cycle t+1).
    task automatic go(input logic [4:0] f, input logic [4:0] l, input logic [7:0] h, input logic [7:0] lp);
        first_addr = f;
        last_addr  = l;
        hold       = h;
        loops      = lp;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    logic [7:0] wrap_exp [8];
`ifdef PATTERN_PLAYER_REVERSE_EN
    logic [7:0] rev_exp [4];
`endif

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
        wrap_exp = '{8'h2E, 8'h2F, 8'h10, 8'h11, 8'h2E, 8'h2F, 8'h10, 8'h11};
`ifdef PATTERN_PLAYER_REVERSE_EN
        rev_exp  = '{8'h11, 8'h10, 8'h2F, 8'h2E};
        reverse  = 1'b0;
`endif
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        first_addr = '0; last_addr = '0; hold = '0; loops = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_fieldp", fieldp, 0);
        chk("rst_pat", pat_out, 0);
        chk("rst_valid", pat_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ok", load_ok, 1);

        // window 2..4, hold 0, one pass; inputs scrambled after start
        go(5'd2, 5'd4, 8'd0, 8'd1);
        first_addr = 5'd9; last_addr = 5'd9; hold = 8'd5; loops = 8'd0;
        chk("t1_busy", busy, 1);
        chk("t1_load_ok", load_ok, 0);
        chk("t1_fieldp", fieldp, 2);
        chk("t1_valid_load", pat_valid, 0);
        step(); chk("t1_b0", pat_out, 8'h12); chk("t1_v0", pat_valid, 1);
        step(); chk("t1_b1", pat_out, 8'h13);
        step(); chk("t1_b2", pat_out, 8'h14); chk("t1_nodone", done, 0);
        step();
        chk("t1_done", done, 1);
        chk("t1_valid_end", pat_valid, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_load_ok_end", load_ok, 1);
        chk("t1_pat_kept", pat_out, 8'h14);
        step(); chk("t1_done_pulse", done, 0);

        // hold 2: three cycles per byte; a start pulse mid-run is ignored
        go(5'd2, 5'd4, 8'd2, 8'd1);
        for (int k = 0; k < 9; k++) begin
            step();
            start = (k == 1);
            chk("t2_byte", pat_out, 8'h12 + 8'(k / 3));
            chk("t2_valid", pat_valid, 1);
        end
        start = 1'b0;
        step();
        chk("t2_done", done, 1);
        chk("t2_valid_end", pat_valid, 0);
        step(); chk("t2_stay_idle", busy, 0);

        // wrapped window 30..1, two passes
        go(5'd30, 5'd1, 8'd0, 8'd2);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t3_byte", pat_out, wrap_exp[k]);
            chk("t3_valid", pat_valid, 1);
            chk("t3_nodone", done, 0);
        end
        step();
        chk("t3_done", done, 1);
        chk("t3_valid_end", pat_valid, 0);

        // infinite passes, aborted by stop sampled at the end of cycle t+10
        go(5'd0, 5'd3, 8'd0, 8'd0);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("t4_byte", pat_out, 8'h10 + 8'(k % 4));
            chk("t4_nodone", done, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_valid_stop", pat_valid, 0);
        chk("t4_busy_stop", busy, 0);
        chk("t4_done_stop", done, 0);
        chk("t4_pat_kept", pat_out, 8'h10);
        step();
        chk("t4_done_after", done, 0);
        chk("t4_pat_kept2", pat_out, 8'h10);

        // reset while holding
        go(5'd5, 5'd8, 8'd3, 8'd1);
        step(); step(); step();
        chk("t5_pre_rst", pat_out, 8'h15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_fieldp", fieldp, 0);
        chk("t5_pat", pat_out, 0);
        chk("t5_valid", pat_valid, 0);
        chk("t5_load_ok", load_ok, 1);
        chk("t5_busy", busy, 0);

        // single-byte window, three passes
        go(5'd5, 5'd5, 8'd0, 8'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_byte", pat_out, 8'h15);
            chk("t6_valid", pat_valid, 1);
            chk("t6_nodone", done, 0);
        end
        step();
        chk("t6_done", done, 1);
        chk("t6_valid_end", pat_valid, 0);

        // start and stop together in IDLE
        first_addr = 5'd7;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_load_ok", load_ok, 1);
        step();
        chk("t7_busy2", busy, 0);
        chk("t7_valid", pat_valid, 0);

`ifdef PATTERN_PLAYER_REVERSE_EN
        reverse = 1'b1;
        go(5'd1, 5'd30, 8'd0, 8'd1);
        reverse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t8_rev_byte", pat_out, rev_exp[k]);
        end
        step();
        chk("t8_rev_done", done, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pattern_player.md
# pattern_player

Downstream consumer of the 32-byte serial pattern buffer. Walks the buffer's `fieldp` read pointer over a programmed address window and captures each selected `field_byte` into a registered output word. Holds each word for a programmable number of cycles and repeats the window a programmed number of passes (or forever). Also gives the serial loader a `load_ok` interlock so the buffer is not shifted during playback.

## Interface
- `buffer_width`, 8: pattern byte width.
- `buffer_size`, 32: buffer depth; address width is 5 bits (log2).
- `hold_width`, 8: width of `hold`.
- `loop_width`, 8: width of `loops`.

- `sclk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin playback; sampled only in IDLE.
- `stop` in 1: abort playback.
- `first_addr` in 5: window start address.
- `last_addr` in 5: window end address.
- `hold` in `hold_width`: each byte is shown for `hold`+1 cycles.
- `loops` in `loop_width`: number of passes; 0 means infinite.
- `field_byte` in `buffer_width`: combinational read data from the buffer.
- `fieldp` out 5: registered read pointer to the buffer.
- `pat_out` out `buffer_width`: registered pattern word.
- `pat_valid` out 1: `pat_out` is live playback data.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the programmed passes complete.
- `load_ok` out 1: equals !`busy`; the serial loader may assert `ssel` only while high.

## Operation
- States: IDLE, LOAD, HOLD.
- Reset values: state IDLE; `fieldp`=0; `pat_out`=0; `pat_valid`=0; `busy`=0; `done`=0; `load_ok`=1. Reset mid-playback has the same effect on the next edge.
- IDLE, `start`=1, `stop`=0:
  - latch `first_addr`, `last_addr`, `hold`, `loops`;
  - `fieldp` <= first; pass counter <= 0; go to LOAD.
- Input changes after `start` have no effect until the next `start`.
- LOAD: `pat_out` <= `field_byte`; `pat_valid` <= 1; hold counter <= hold; `fieldp` <= next(first); go to HOLD.
- next(a) = first if a == last, else (a+1) mod 32.
- The window wraps 31→0 when last < first. first == last gives a one-byte window.
- HOLD, hold counter != 0: decrement the counter.
- HOLD, hold counter == 0 and the shown byte's address != last: `pat_out` <= `field_byte`; `fieldp` <= next(`fieldp`); hold counter <= hold.
- HOLD, hold counter == 0 and the shown byte's address == last (pass complete):
  - if `loops` != 0 and pass counter == `loops`−1: go to IDLE, `pat_valid` <= 0, `done` <= 1 for one cycle;
  - otherwise increment the pass counter (saturating at max when `loops`=0) and load the first byte exactly as in the previous bullet.
- `stop`=1 in LOAD or HOLD: go to IDLE next edge; `pat_valid` <= 0; no `done`.
- `start` and `stop` together in IDLE: stop wins, stay IDLE. `start` while busy is ignored.
- `pat_out` keeps its last value in IDLE; only `pat_valid` drops.

## Timing
- `start` sampled at edge t → LOAD during t+1 (`fieldp`=first) → first byte on `pat_out` with `pat_valid`=1 from t+2.
- Each byte is visible for exactly `hold`+1 cycles. Consecutive bytes have no gap, including across pass boundaries.
- `done` and `pat_valid`=0 appear in the cycle after the final byte's last hold cycle. `busy` falls in the same cycle.
- `load_ok` is combinational from state; there is no extra latency.

## Configuration
- `PATTERN_PLAYER_REVERSE_EN` defined: adds input `reverse` (1 bit), latched at `start`.
  - When latched 1: next(a) = first if a == last, else (a−1) mod 32; wrap is 0→31.
- Macro undefined: no `reverse` port; ascending order only.

## Structure
- Shared package `pattern_pkg`:
  - `PAT_ADDR_W`=5, `PAT_BUF_SIZE`=32, `PAT_BYTE_W`=8;
  - state enum `pat_state_t` {IDLE, LOAD, HOLD};
  - shared with `patternbuf` users.
- One sub-module, `pattern_addr_gen`: combinational next-address with wrap and optional reverse. It is reused by the loader's address checks.

## Test plan
- Buffer loaded with mem[i]=0x10+i; first=2, last=4, hold=0, loops=1; `start` at t → `pat_out` 0x12/0x13/0x14 at t+2/t+3/t+4, `done`=1 and `pat_valid`=0 at t+5.
- Same window with hold=2 → each byte held 3 cycles; `done` at t+11.
- first=30, last=1, hold=0, loops=2 → sequence 0x2E,0x2F,0x10,0x11 twice with no gap, then `done`. With the macro and `reverse`=1 and first=1, last=30 → 0x11,0x10,0x2F,0x2E.
- loops=0, then `stop` at cycle t+10 → `pat_valid`=0 and `busy`=0 at t+11, `done` never asserted, `pat_out` holds its value.
- `rst` asserted during HOLD → next cycle `fieldp`=0, `pat_out`=0, `pat_valid`=0, `load_ok`=1.
- first=last=5, loops=3, hold=0 → 0x15 for 3 cycles; `done` at t+5. `start`+`stop` together in IDLE → stays IDLE.
